altera_tse_reset_sequencer: RTL and testbench

Sequences reset release for the TSE datapath once the asynchronously asserted, synchronously released system reset has been conditioned by the per-clock reset synchronizer. The block sits directly downstream of that synchronizer in each clock domain. It holds PCS and MAC logic in reset until the reference PLL has been locked and stable for a programmable time, then releases PCS first and MAC after a stage delay. On PLL lock loss or a software reset request it re-asserts both resets and re-runs the sequence.

---
 rtl/altera_tse_reset_sequencer.sv | 121 ++++++++++++
 tb/tb_altera_tse_reset_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/altera_tse_reset_sequencer.sv
// ============================================================================
// Module   : altera_tse_reset_sequencer
// Brief    : Staged PCS/MAC reset release gated on a stable, synchronized PLL lock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module altera_tse_reset_sequencer #(
    parameter int MIN_ASSERT         = 8,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_DELAY        = 16,
    parameter int SYNC_DEPTH         = 2,
    parameter int CNT_WIDTH          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       sw_reset,
    output logic       pcs_reset_out,
    output logic       mac_reset_out,
    output logic       ready,
    output logic [7:0] lock_loss_count
);

    localparam logic [CNT_WIDTH-1:0] c_assert_last = CNT_WIDTH'(MIN_ASSERT - 1);
    localparam logic [CNT_WIDTH-1:0] c_stable_last = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_stage_last  = CNT_WIDTH'(STAGE_DELAY - 1);

    typedef enum logic [2:0] {
        ST_ASSERT      = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_WAIT_STABLE = 3'd2,
        ST_REL_PCS     = 3'd3,
        ST_RUN         = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [SYNC_DEPTH-1:0]  sync_q;
    logic                   pcs_q, pcs_d;
    logic                   mac_q, mac_d;
    logic                   ready_q, ready_d;
    logic [7:0]             llc_q, llc_d;
    logic                   locked_s;
    logic                   lock_lost;

    assign locked_s = sync_q[SYNC_DEPTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], pll_locked};
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_lost = ((state_q == ST_REL_PCS) || (state_q == ST_RUN)) && !locked_s;

        if (sw_reset || lock_lost) begin
            state_d = ST_ASSERT;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == c_assert_last) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) state_d = ST_WAIT_STABLE;
                end
                ST_WAIT_STABLE: begin
                    if (!locked_s)                   state_d = ST_WAIT_LOCK;
                    else if (cnt_q == c_stable_last) state_d = ST_REL_PCS;
                end
                ST_REL_PCS: begin
                    if (cnt_q == c_stage_last) state_d = ST_RUN;
                end
                ST_RUN:  state_d = ST_RUN;
                default: state_d = ST_ASSERT;
            endcase
        end

        // Held sw_reset pins the counter so MIN_ASSERT counts from its release.
        if ((state_d != state_q) || sw_reset) cnt_d = '0;
        else                                  cnt_d = cnt_q + 1'b1;

        if (lock_lost && (llc_q != 8'hFF)) llc_d = llc_q + 8'd1;
        else                               llc_d = llc_q;

        pcs_d   = (state_d == ST_ASSERT) || (state_d == ST_WAIT_LOCK) ||
                  (state_d == ST_WAIT_STABLE);
        mac_d   = (state_d != ST_RUN);
        ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            pcs_q   <= 1'b1;
            mac_q   <= 1'b1;
            ready_q <= 1'b0;
            llc_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pcs_q   <= pcs_d;
            mac_q   <= mac_d;
            ready_q <= ready_d;
            llc_q   <= llc_d;
        end
    end

    assign pcs_reset_out   = pcs_q;
    assign mac_reset_out   = mac_q;
    assign ready           = ready_q;
    assign lock_loss_count = llc_q;

endmodule

`default_nettype wire

// File: tb/tb_altera_tse_reset_sequencer.sv
// ============================================================================
// Module   : tb_altera_tse_reset_sequencer
// Brief    : Directed plus randomized check of the reset sequencer against a phase model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_altera_tse_reset_sequencer;

    localparam int MA = 4;
    localparam int LS = 8;
    localparam int SD = 3;
    localparam int SY = 2;
    localparam int CW = 8;

    localparam int P_ASSERT = 0;
    localparam int P_WL     = 1;
    localparam int P_WS     = 2;
    localparam int P_REL    = 3;
    localparam int P_RUN    = 4;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       pll_locked = 1'b0;
    logic       sw_reset   = 1'b0;
    logic       pcs_reset_out;
    logic       mac_reset_out;
    logic       ready;
    logic [7:0] lock_loss_count;

    int n_vec = 0;
    int n_err = 0;

    int m_ph;
    int m_held;
    int m_llc;
    int edge_n;
    bit hist[$];
    bit prev_pcs;
    bit prev_mac;

    always #5 clk = ~clk;

    altera_tse_reset_sequencer #(
        .MIN_ASSERT         (MA),
        .LOCK_STABLE_CYCLES (LS),
        .STAGE_DELAY        (SD),
        .SYNC_DEPTH         (SY),
        .CNT_WIDTH          (CW)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .sw_reset        (sw_reset),
        .pcs_reset_out   (pcs_reset_out),
        .mac_reset_out   (mac_reset_out),
        .ready           (ready),
        .lock_loss_count (lock_loss_count)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_ph   = P_ASSERT;
        m_held = 0;
        m_llc  = 0;
        edge_n = 0;
        hist.delete();
        for (int i = 0; i < SY; i++) hist.push_back(1'b0);
        prev_pcs = 1'b1;
        prev_mac = 1'b1;
    endfunction

    // Phase model: m_held is the number of edges already spent in the phase.
    function automatic void model_edge(input bit pll, input bit sw);
        bit ls;
        bit lost;
        int nxt;
        ls = hist[$];
        hist.push_front(pll);
        void'(hist.pop_back());
        edge_n++;
        lost = (m_ph >= P_REL) && !ls;
        if (lost && m_llc < 255) m_llc++;
        nxt = m_ph;
        if (sw || lost) begin
            nxt = P_ASSERT;
        end else begin
            case (m_ph)
                P_ASSERT: if (m_held + 1 >= MA) nxt = P_WL;
                P_WL:     if (ls) nxt = P_WS;
                P_WS:     if (!ls) nxt = P_WL; else if (m_held + 1 >= LS) nxt = P_REL;
                P_REL:    if (m_held + 1 >= SD) nxt = P_RUN;
                default:  nxt = m_ph;
            endcase
        end
        if (nxt != m_ph || sw) m_held = 0;
        else                   m_held++;
        m_ph = nxt;
    endfunction

    task automatic check_all();
        chk("pcs",   {7'b0, pcs_reset_out}, 8'(m_ph < P_REL));
        chk("mac",   {7'b0, mac_reset_out}, 8'(m_ph < P_RUN));
        chk("ready", {7'b0, ready},         8'(m_ph == P_RUN));
        chk("llc",   lock_loss_count,       8'(m_llc));
        chk("mac_low_while_pcs_high", {7'b0, pcs_reset_out & ~mac_reset_out}, 8'd0);
        chk("joint_release", {7'b0, prev_pcs & prev_mac & ~pcs_reset_out & ~mac_reset_out}, 8'd0);
        prev_pcs = pcs_reset_out;
        prev_mac = mac_reset_out;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(pll_locked, sw_reset);
        #1;
        check_all();
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pcs",   {7'b0, pcs_reset_out}, 8'd1);
        chk("async_rst_mac",   {7'b0, mac_reset_out}, 8'd1);
        chk("async_rst_ready", {7'b0, ready},         8'd0);
        chk("async_rst_llc",   lock_loss_count,       8'd0);
        #2 reset = 1'b0;
        model_reset();
    endtask

    task automatic run_until_pcs_low(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (pcs_reset_out === 1'b0) begin
                at = edge_n;
                break;
            end
        end
        chk("pcs_release_in_budget", 8'(at >= 0), 8'd1);
    endtask

    task automatic run_until_ready(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (ready === 1'b1) begin
                at = edge_n;
                break;
            end
        end
        chk("ready_in_budget", 8'(at >= 0), 8'd1);
    endtask

    initial begin
        int at;
        int base;

        pll_locked = 1'b1;
        model_reset();
        #12;
        chk("reset_pcs",   {7'b0, pcs_reset_out}, 8'd1);
        chk("reset_mac",   {7'b0, mac_reset_out}, 8'd1);
        chk("reset_ready", {7'b0, ready},         8'd0);
        chk("reset_llc",   lock_loss_count,       8'd0);
        reset = 1'b0;

        // Default bring-up
        run_until_pcs_low(40, at);
        chk("bringup_pcs_edge", 8'(at), 8'd13);
        run_until_ready(20, at);
        chk("bringup_ready_edge", 8'(at), 8'd16);
        chk("bringup_mac", {7'b0, mac_reset_out}, 8'd0);

        // Software reset held 10 cycles in RUN
        sw_reset = 1'b1;
        step();
        chk("sw_first_edge_pcs",   {7'b0, pcs_reset_out}, 8'd1);
        chk("sw_first_edge_ready", {7'b0, ready},         8'd0);
        repeat (9) step();
        sw_reset = 1'b0;
        base = edge_n;
        run_until_pcs_low(40, at);
        chk("sw_pcs_edge", 8'(at - base), 8'd13);
        run_until_ready(20, at);
        chk("sw_llc_unchanged", lock_loss_count, 8'd0);

        // Lock loss in RUN, repeated to saturation
        for (int i = 0; i < 260; i++) begin
            pll_locked = 1'b0;
            repeat (3) step();
            pll_locked = 1'b1;
            if (i == 0) chk("llc_first_loss", lock_loss_count, 8'd1);
            run_until_ready(60, at);
        end
        chk("llc_saturated", lock_loss_count, 8'd255);

        // Lock bounce during stabilization
        pulse_reset();
        repeat (8) step();
        pll_locked = 1'b0;
        repeat (3) step();
        pll_locked = 1'b1;
        run_until_pcs_low(40, at);
        chk("bounce_pcs_edge", 8'(at), 8'd22);
        chk("bounce_llc", lock_loss_count, 8'd0);

        // Simultaneous sw_reset and lock loss while in REL_PCS
        pll_locked = 1'b0;
        repeat (2) step();
        sw_reset = 1'b1;
        step();
        sw_reset   = 1'b0;
        pll_locked = 1'b1;
        chk("simul_pcs", {7'b0, pcs_reset_out}, 8'd1);
        chk("simul_llc", lock_loss_count, 8'd1);

        // Randomized lock and software-reset activity
        for (int i = 0; i < 2000; i++) begin
            if (pll_locked) pll_locked = ($urandom_range(0, 99) >= 2);
            else            pll_locked = ($urandom_range(0, 99) < 20);
            sw_reset = ($urandom_range(0, 99) < 2);
            step();
        end

        // Async reset pulse mid-REL_PCS, then full restart
        sw_reset   = 1'b0;
        pll_locked = 1'b1;
        run_until_pcs_low(100, at);
        pulse_reset();
        run_until_pcs_low(40, at);
        chk("restart_pcs_edge", 8'(at), 8'd13);
        run_until_ready(20, at);
        chk("restart_ready_edge", 8'(at), 8'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
